// File: rtl/idma_obi_write.sv
// OBI write back-end for the iDMA: turns aligned buffer bytes into masked OBI write beats.
// Define IDMA_OBI_WRITE_MASK_DATA_EN to drive 0 on every write-data byte that is not enabled.
module idma_obi_write #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned OffW          = $clog2(StrbWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [7:0]           w_dp_num_beats_i,
    input  logic [OffW-1:0]      w_dp_offset_i,
    input  logic [OffW-1:0]      w_dp_tailer_i,
    input  logic                 w_dp_valid_i,
    output logic                 w_dp_ready_o,
    output logic                 w_dp_err_o,
    output logic                 w_dp_valid_o,
    input  logic                 w_dp_ready_i,
    input  logic [DataWidth-1:0] buffer_out_i,
    input  logic [StrbWidth-1:0] buffer_out_valid_i,
    output logic [StrbWidth-1:0] buffer_out_ready_o,
    input  logic                 dp_poison_i,
    output logic                 obi_req_o,
    output logic                 obi_we_o,
    output logic [AddrWidth-1:0] obi_addr_o,
    output logic [StrbWidth-1:0] obi_be_o,
    output logic [DataWidth-1:0] obi_wdata_o,
    input  logic                 obi_gnt_i,
    input  logic                 obi_rvalid_i,
    input  logic                 obi_err_i,
    output logic                 busy_o
);

    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {StIdle, StSend, StDrain, StResp} state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [7:0]             beats_q, beats_d;
    logic                   first_q, first_d;
    logic [OffW-1:0]        offset_q, offset_d;
    logic [OffW-1:0]        tailer_q, tailer_d;
    logic                   err_q, err_d;
    logic [OutW-1:0]        outst_q, outst_d;

    logic                   last_beat;
    logic [StrbWidth-1:0]   mask;
    logic                   inc, dec;

    assign last_beat = (beats_q == 8'd0);

    always_comb begin
        mask = '1;
        for (int unsigned i = 0; i < StrbWidth; i++) begin
            if (first_q && (i < 32'(offset_q))) begin
                mask[i] = 1'b0;
            end
            if (last_beat && (tailer_q != '0) && (i >= 32'(tailer_q))) begin
                mask[i] = 1'b0;
            end
        end
    end

    // Request only once every byte this beat needs is present and a response slot is free.
    assign obi_req_o = (state_q == StSend) && ((buffer_out_valid_i & mask) == mask) &&
                       (32'(outst_q) < MaxOutstanding);
    assign obi_we_o   = obi_req_o;
    assign obi_addr_o = addr_q;
    assign obi_be_o   = (state_q == StSend && !dp_poison_i) ? mask : '0;

`ifdef IDMA_OBI_WRITE_MASK_DATA_EN
    always_comb begin
        obi_wdata_o = '0;
        for (int unsigned i = 0; i < StrbWidth; i++) begin
            obi_wdata_o[8*i +: 8] = obi_be_o[i] ? buffer_out_i[8*i +: 8] : 8'h00;
        end
    end
`else
    assign obi_wdata_o = (state_q == StSend) ? buffer_out_i : '0;
`endif

    // Stray responses with nothing outstanding are dropped.
    assign inc = obi_req_o & obi_gnt_i;
    assign dec = obi_rvalid_i & (outst_q != '0);

    always_comb begin
        outst_d = outst_q;
        if (inc && !dec) begin
            outst_d = outst_q + OutW'(1);
        end else if (!inc && dec) begin
            outst_d = outst_q - OutW'(1);
        end
    end

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        beats_d            = beats_q;
        first_d            = first_q;
        offset_d           = offset_q;
        tailer_d           = tailer_q;
        err_d              = err_q | (obi_rvalid_i & obi_err_i);
        aw_ready_o         = 1'b0;
        w_dp_ready_o       = 1'b0;
        w_dp_valid_o       = 1'b0;
        w_dp_err_o         = 1'b0;
        buffer_out_ready_o = '0;
        busy_o             = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (rst_ni && aw_valid_i && w_dp_valid_i) begin
                    aw_ready_o   = 1'b1;
                    w_dp_ready_o = 1'b1;
                    addr_d       = aw_addr_i & ~AddrWidth'(StrbWidth - 1);
                    beats_d      = w_dp_num_beats_i;
                    first_d      = 1'b1;
                    offset_d     = w_dp_offset_i;
                    tailer_d     = w_dp_tailer_i;
                    err_d        = 1'b0;
                    state_d      = StSend;
                end
            end
            StSend: begin
                if (inc) begin
                    buffer_out_ready_o = mask;
                    addr_d             = addr_q + AddrWidth'(StrbWidth);
                    first_d            = 1'b0;
                    beats_d            = beats_q - 8'd1;
                    if (last_beat) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // No requests here, so only a response can move the counter.
                if ((outst_q == '0) || ((outst_q == OutW'(1)) && obi_rvalid_i)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                w_dp_valid_o = 1'b1;
                w_dp_err_o   = err_q;
                if (w_dp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            beats_q  <= '0;
            first_q  <= 1'b0;
            offset_q <= '0;
            tailer_q <= '0;
            err_q    <= 1'b0;
            outst_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beats_q  <= beats_d;
            first_q  <= first_d;
            offset_q <= offset_d;
            tailer_q <= tailer_d;
            err_q    <= err_d;
            outst_q  <= outst_d;
        end
    end

endmodule

// File: tb/tb_idma_obi_write.sv
// Self-checking bench for idma_obi_write: handshake/mask tables, directed corner cases and
// randomized bursts scored against a per-beat reference model.
module tb_idma_obi_write;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] aw_addr = '0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [7:0]  num_beats = '0;
    logic [1:0]  offset = '0, tailer = '0;
    logic        dp_valid = 1'b0, dp_ready, dp_err, dpo_valid;
    logic        dpo_ready = 1'b0;
    logic [31:0] buf_data = '0;
    logic [3:0]  buf_valid = '0, buf_ready;
    logic        poison = 1'b0;
    logic        req, we;
    logic [31:0] addr_o, wdata;
    logic [3:0]  be;
    logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0, busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] got_addr[$];
    logic [3:0]  got_be[$];
    int          gnt_cyc[$];
    logic        last_err;

    always #5 clk = ~clk;

    idma_obi_write dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .aw_addr_i          (aw_addr),
        .aw_valid_i         (aw_valid),
        .aw_ready_o         (aw_ready),
        .w_dp_num_beats_i   (num_beats),
        .w_dp_offset_i      (offset),
        .w_dp_tailer_i      (tailer),
        .w_dp_valid_i       (dp_valid),
        .w_dp_ready_o       (dp_ready),
        .w_dp_err_o         (dp_err),
        .w_dp_valid_o       (dpo_valid),
        .w_dp_ready_i       (dpo_ready),
        .buffer_out_i       (buf_data),
        .buffer_out_valid_i (buf_valid),
        .buffer_out_ready_o (buf_ready),
        .dp_poison_i        (poison),
        .obi_req_o          (req),
        .obi_we_o           (we),
        .obi_addr_o         (addr_o),
        .obi_be_o           (be),
        .obi_wdata_o        (wdata),
        .obi_gnt_i          (gnt),
        .obi_rvalid_i       (rvalid),
        .obi_err_i          (err),
        .busy_o             (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Enabled bytes of beat i: the range [lo, hi) of byte lanes.
    function automatic logic [3:0] nom_be(input int i, input int last, input int off,
                                          input int tail);
        int lo, hi;
        logic [3:0] r;
        lo = (i == 0) ? off : 0;
        hi = (i == last && tail != 0) ? tail : 4;
        for (int b = 0; b < 4; b++) r[b] = (b >= lo) && (b < hi);
        return r;
    endfunction

    task automatic run_burst(input logic [31:0] a, input int beats, input int off, input int tail,
                             input int gnt_pct, input int bv_pct, input int lat_min,
                             input int lat_max, input int err_idx, input int poison_idx);
        int n, granted, rdone, cyc, last_due, resp_wait, due;
        int due_q[$];
        logic err_exp, rv, grant, done, exp_req;
        logic [3:0] nom, exp_be;
        logic [31:0] exp_addr, exp_wdata;
        n = beats + 1; granted = 0; rdone = 0; cyc = 0; last_due = -1;
        resp_wait = $urandom_range(0, 2);
        err_exp = 1'b0; done = 1'b0;
        got_addr.delete(); got_be.delete(); gnt_cyc.delete();

        @(posedge clk); #1;
        aw_addr = a; aw_valid = 1'b1; dp_valid = 1'b1;
        num_beats = 8'(beats); offset = 2'(off); tailer = 2'(tail);
        @(negedge clk);
        chk("aw_ready_accept", aw_ready, 1);
        chk("dp_ready_accept", dp_ready, 1);
        @(posedge clk); #1;
        aw_valid = 1'b0; dp_valid = 1'b0;

        while (!done) begin
            rv = (due_q.size() > 0) && (due_q[0] <= cyc);
            rvalid = rv;
            err = rv && (rdone == err_idx);
            nom = (granted < n) ? nom_be(granted, beats, off, tail) : 4'hF;
            buf_valid = ($urandom_range(0, 99) < bv_pct) ? 4'hF : 4'($urandom);
            buf_data = $urandom;
            poison = (granted == poison_idx);
            @(negedge clk);
            exp_req = (granted < n) && ((buf_valid & nom) == nom) && (granted - rdone < 2);
            chk("req", req, exp_req);
            chk("busy", busy, 1);
            chk("resp_valid", dpo_valid, (granted == n) && (rdone == n));
            if (exp_req && req) begin
                exp_be = poison ? 4'h0 : nom;
                exp_addr = (a & ~32'h3) + 32'(4 * granted);
`ifdef IDMA_OBI_WRITE_MASK_DATA_EN
                for (int b = 0; b < 4; b++)
                    exp_wdata[8*b +: 8] = exp_be[b] ? buf_data[8*b +: 8] : 8'h00;
`else
                exp_wdata = buf_data;
`endif
                chk("addr", addr_o, exp_addr);
                chk("be", be, exp_be);
                chk("wdata", wdata, exp_wdata);
                chk("we", we, 1);
            end
            gnt = ($urandom_range(0, 99) < gnt_pct);
            grant = exp_req && gnt;
            #1;
            chk("buf_ready", buf_ready, grant ? nom : 4'h0);
            if ((granted == n) && (rdone == n)) begin
                chk("resp_err", dp_err, err_exp);
                last_err = dp_err;
                if (resp_wait == 0) begin
                    dpo_ready = 1'b1; aw_valid = 1'b1; dp_valid = 1'b1;
                    #1;
                    chk("no_accept_in_resp", aw_ready, 0);
                    done = 1'b1;
                end else begin
                    resp_wait--;
                end
            end
            if (grant) begin
                got_addr.push_back(addr_o);
                got_be.push_back(be);
                gnt_cyc.push_back(cyc);
                granted++;
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                due_q.push_back(due);
            end
            if (rv) begin
                void'(due_q.pop_front());
                rdone++;
                err_exp = err_exp | err;
            end
            @(posedge clk); #1;
            cyc++;
            if (!done && cyc > 400) begin
                checks++; errors++;
                $display("FAIL burst_timeout: still busy after %0d cycles", cyc);
                rst_ni = 1'b0; #1; rst_ni = 1'b1;
                break;
            end
        end
        gnt = 1'b0; rvalid = 1'b0; err = 1'b0; dpo_ready = 1'b0;
        aw_valid = 1'b0; dp_valid = 1'b0; poison = 1'b0; buf_valid = '0;
        if (done) chk("idle_after_resp", busy, 0);
    endtask

    typedef struct {
        logic aw; logic dp; logic exp_rdy;
    } hs_t;

    typedef struct {
        logic [31:0] a; int beats; int off; int tail;
        logic [31:0] exp_addr0; logic [3:0] exp_be0; logic [3:0] exp_bel;
    } vec_t;

    hs_t  hs_tab[4];
    vec_t vec_tab[6];

    initial begin
        hs_tab[0] = '{1'b0, 1'b0, 1'b0};
        hs_tab[1] = '{1'b1, 1'b0, 1'b0};
        hs_tab[2] = '{1'b0, 1'b1, 1'b0};
        hs_tab[3] = '{1'b1, 1'b1, 1'b1};
        vec_tab[0] = '{32'h0000_1002, 0, 2, 3, 32'h0000_1000, 4'b0100, 4'b0100};
        vec_tab[1] = '{32'h0000_2000, 3, 0, 0, 32'h0000_2000, 4'hF, 4'hF};
        vec_tab[2] = '{32'h0000_3001, 1, 1, 2, 32'h0000_3000, 4'hE, 4'h3};
        vec_tab[3] = '{32'h0000_4003, 0, 3, 0, 32'h0000_4000, 4'h8, 4'h8};
        vec_tab[4] = '{32'h0000_5000, 2, 0, 1, 32'h0000_5000, 4'hF, 4'h1};
        vec_tab[5] = '{32'hFFFF_FFFC, 1, 0, 0, 32'hFFFF_FFFC, 4'hF, 4'hF};

        // Reset: outputs must stay 0 even with requests pending on the inputs.
        aw_valid = 1'b1; dp_valid = 1'b1; buf_valid = 4'hF; buf_data = 32'hDEAD_BEEF;
        #3;
        chk("rst_aw_ready", aw_ready, 0);
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_be", be, 0);
        chk("rst_resp", dpo_valid, 0);
        aw_valid = 1'b0; dp_valid = 1'b0; buf_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        foreach (hs_tab[i]) begin
            @(negedge clk);
            aw_valid = hs_tab[i].aw; dp_valid = hs_tab[i].dp;
            #1;
            chk("hs_aw_ready", aw_ready, hs_tab[i].exp_rdy);
            chk("hs_dp_ready", dp_ready, hs_tab[i].exp_rdy);
            aw_valid = 1'b0; dp_valid = 1'b0;
        end

        foreach (vec_tab[i]) begin
            run_burst(vec_tab[i].a, vec_tab[i].beats, vec_tab[i].off, vec_tab[i].tail,
                      100, 100, 1, 1, -1, -1);
            chk("vec_nbeats", got_addr.size(), vec_tab[i].beats + 1);
            if (got_addr.size() == vec_tab[i].beats + 1) begin
                chk("vec_addr0", got_addr[0], vec_tab[i].exp_addr0);
                chk("vec_be0", got_be[0], vec_tab[i].exp_be0);
                chk("vec_be_last", got_be[vec_tab[i].beats], vec_tab[i].exp_bel);
            end
        end

        // Full throughput: one grant per cycle starting the cycle after acceptance.
        run_burst(32'h0000_2000, 3, 0, 0, 100, 100, 1, 1, -1, -1);
        chk("tp_count", gnt_cyc.size(), 4);
        if (gnt_cyc.size() == 4) begin
            chk("tp_first", gnt_cyc[0], 0);
            chk("tp_last", gnt_cyc[3], 3);
            chk("tp_addr3", got_addr[3], 32'h0000_200C);
        end

        // Back-pressure: two grants, then wait for the first response at cycle 5.
        run_burst(32'h0000_3000, 3, 0, 0, 100, 100, 5, 5, -1, -1);
        chk("bp_count", gnt_cyc.size(), 4);
        if (gnt_cyc.size() == 4) begin
            chk("bp_second", gnt_cyc[1], 1);
            chk("bp_resume", gnt_cyc[2], 6);
        end

        run_burst(32'h0000_4000, 2, 0, 0, 100, 100, 1, 2, 1, -1);
        chk("err_sticky", last_err, 1);
        run_burst(32'h0000_4100, 0, 0, 0, 100, 100, 1, 1, -1, -1);
        chk("err_cleared", last_err, 0);

        run_burst(32'h0000_5000, 1, 0, 0, 100, 100, 1, 1, -1, 0);
        if (got_be.size() == 2) begin
            chk("poison_be0", got_be[0], 4'h0);
            chk("poison_be1", got_be[1], 4'hF);
        end

        // Wrap, then reset while the second beat waits for its grant.
        @(posedge clk); #1;
        aw_addr = 32'hFFFF_FFFC; num_beats = 8'd1; offset = 2'd0; tailer = 2'd0;
        aw_valid = 1'b1; dp_valid = 1'b1;
        @(posedge clk); #1;
        aw_valid = 1'b0; dp_valid = 1'b0; buf_valid = 4'hF; buf_data = 32'h1234_5678;
        @(negedge clk);
        chk("wrap_addr0", addr_o, 32'hFFFF_FFFC);
        chk("wrap_req0", req, 1);
        gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0;
        @(negedge clk);
        chk("wrap_addr1", addr_o, 32'h0000_0000);
        chk("wrap_req1", req, 1);
        rst_ni = 1'b0; aw_valid = 1'b1; dp_valid = 1'b1; gnt = 1'b1; rvalid = 1'b1;
        #1;
        chk("midrst_req", req, 0);
        chk("midrst_we", we, 0);
        chk("midrst_addr", addr_o, 0);
        chk("midrst_be", be, 0);
        chk("midrst_wdata", wdata, 0);
        chk("midrst_buf_ready", buf_ready, 0);
        chk("midrst_aw_ready", aw_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_resp", {dpo_valid, dp_err}, 0);
        @(posedge clk); #1;
        aw_valid = 1'b0; dp_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0; buf_valid = '0;
        rst_ni = 1'b1;

        for (int k = 0; k < 30; k++) begin
            int bt;
            bt = $urandom_range(0, 7);
            run_burst($urandom, bt, $urandom_range(0, 3), $urandom_range(0, 3), 70, 75, 1, 4,
                      int'($urandom_range(0, bt + 1)) - 1, int'($urandom_range(0, bt + 2)) - 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
